// File: rtl/warbler_pkg.sv
// warbler_pkg: shared state encoding and NLFSR3 geometry for the warbler controller
package warbler_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, INIT, RUN} state_t;
  localparam int NLFSR_STAGES = 6;
  localparam int NLFSR_W = 5;
  localparam int SEED_W = NLFSR_STAGES * NLFSR_W;
endpackage

// File: rtl/warbler_ks_pack.sv
// warbler_ks_pack: MSB-first keystream bit packer with a valid/ready output word register
module warbler_ks_pack #(
  parameter int KS_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_sample,
  input  logic            i_bit,
  input  logic            i_ready,
  output logic            o_stall,
  output logic            o_valid,
  output logic [KS_W-1:0] o_data
);
  localparam int CW = $clog2(KS_W);
  localparam logic [CW-1:0] LAST = CW'(KS_W - 1);
  logic [CW-1:0]   r_cnt;
  logic [KS_W-2:0] r_sh;
  logic            r_valid;
  logic [KS_W-1:0] r_data;
  logic            w_full;
  logic            w_done;
  logic [KS_W-1:0] w_word;
  assign w_full  = r_cnt == LAST;
  assign w_word  = {r_sh, i_bit};
  assign w_done  = i_sample & w_full;
  assign o_stall = w_full & r_valid & ~i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  // shift in sampled bits; on the last bit hand the word over, a word landing while the old one drains keeps valid high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_sh    <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_sample) begin
        r_sh  <= w_word[KS_W-2:0];
        r_cnt <= w_full ? '0 : r_cnt + CW'(1);
      end
      r_valid <= w_done | (r_valid & ~i_ready);
      if (w_done) r_data <= w_word;
    end
  end
endmodule

// File: rtl/warbler_ctrl.sv
// warbler_ctrl: seeds and steps an external NLFSR3 and packs its keystream bits into words
module warbler_ctrl import warbler_pkg::*; #(
  parameter int INIT_ROUNDS = 30,
  parameter int KS_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seed_valid,
  output logic               seed_ready,
  input  logic [SEED_W-1:0]  seed,
  input  logic               abort,
  input  logic [NLFSR_W-1:0] tk_i,
  output logic               load,
  output logic               init,
  output logic               nlfsr3_ce,
  output logic [NLFSR_W-1:0] d3,
  output logic [NLFSR_W-1:0] tk,
  input  logic               warbler_bit,
  output logic               ks_valid,
  input  logic               ks_ready,
  output logic [KS_W-1:0]    ks_data,
  output logic               busy
);
  localparam logic [7:0] LAST_LOAD = 8'(NLFSR_STAGES - 1);
  localparam logic [7:0] LAST_INIT = 8'(INIT_ROUNDS - 1);
  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_nx;
  logic [SEED_W-1:0] r_seed;
  logic              w_stall;
  assign busy = r_state != IDLE;
  assign tk   = tk_i;
  // state and phase counter; the seed shifts up one chunk per LOAD cycle so d3 always reads the top chunk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_seed  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nx;
      if (seed_valid & seed_ready & ~abort) r_seed <= seed;
      else if (r_state == LOAD) r_seed <= r_seed << NLFSR_W;
    end
  end
  // next state and NLFSR3 controls; abort overrides every transition
  always_comb begin
    w_next     = r_state;
    w_cnt_nx   = r_cnt;
    seed_ready = 1'b0;
    load       = 1'b0;
    init       = 1'b0;
    nlfsr3_ce  = 1'b0;
    d3         = '0;
    case (r_state)
      IDLE: begin
        seed_ready = 1'b1;
        if (seed_valid) w_next = LOAD;
      end
      LOAD: begin
        load      = 1'b1;
        nlfsr3_ce = 1'b1;
        d3        = r_seed[SEED_W-1 -: NLFSR_W];
        w_cnt_nx  = r_cnt == LAST_LOAD ? 8'd0 : r_cnt + 8'd1;
        if (r_cnt == LAST_LOAD) w_next = INIT;
      end
      INIT: begin
        init      = 1'b1;
        nlfsr3_ce = 1'b1;
        w_cnt_nx  = r_cnt == LAST_INIT ? 8'd0 : r_cnt + 8'd1;
        if (r_cnt == LAST_INIT) w_next = RUN;
      end
      RUN: nlfsr3_ce = ~w_stall;
      default: w_next = IDLE;
    endcase
    if (abort) begin
      w_next   = IDLE;
      w_cnt_nx = '0;
    end
  end
  warbler_ks_pack #(.KS_W(KS_W)) u_pack (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (abort),
    .i_sample ((r_state == RUN) & nlfsr3_ce),
    .i_bit    (warbler_bit),
    .i_ready  (ks_ready),
    .o_stall  (w_stall),
    .o_valid  (ks_valid),
    .o_data   (ks_data)
  );
endmodule

// File: tb/tb_warbler_ctrl.sv
// tb_warbler_ctrl: checks two warbler_ctrl configurations against a phase/bit-list reference model
module tb_warbler_ctrl;
  logic clk = 1'b0;
  logic rst, seed_valid, abort, warbler_bit, ks_ready;
  logic [29:0] seed;
  logic [4:0] tk_i;
  logic sr0, ld0, in0, ce0, v0, b0, sr1, ld1, in1, ce1, v1, b1;
  logic [4:0] d30, tk0, d31, tk1;
  logic [7:0] dat0;
  logic [1:0] dat1;
  int checks = 0, failures = 0;
  int md[2], el[2], pn[2], pw[2];
  logic [29:0] ms[2];
  logic mv[2];
  logic [31:0] mdat[2];
  int rr[2] = '{30, 1};
  int ww[2] = '{8, 2};
  int pat[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
  int n;

  always #5 clk = ~clk;

  warbler_ctrl #(.INIT_ROUNDS(30), .KS_W(8)) dut0 (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_ready(sr0), .seed(seed), .abort(abort),
    .tk_i(tk_i), .load(ld0), .init(in0), .nlfsr3_ce(ce0), .d3(d30), .tk(tk0),
    .warbler_bit(warbler_bit), .ks_valid(v0), .ks_ready(ks_ready), .ks_data(dat0), .busy(b0));

  warbler_ctrl #(.INIT_ROUNDS(1), .KS_W(2)) dut1 (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_ready(sr1), .seed(seed), .abort(abort),
    .tk_i(tk_i), .load(ld1), .init(in1), .nlfsr3_ce(ce1), .d3(d31), .tk(tk1),
    .warbler_bit(warbler_bit), .ks_valid(v1), .ks_ready(ks_ready), .ks_data(dat1), .busy(b1));

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h at %0t", tag, k, obs, exp, $time);
    end
  endtask

  function automatic logic exp_ce(input int k);
    return md[k] == 1 || md[k] == 2 ||
           (md[k] == 3 && !(pn[k] == ww[k] - 1 && mv[k] && !ks_ready));
  endfunction

  task automatic check_dut(input int k, input logic sr, input logic ld, input logic ini, input logic ce,
                           input logic [4:0] d3, input logic [4:0] tk, input logic v,
                           input logic [31:0] dat, input logic b);
    logic [29:0] sh;
    sh = ms[k] >> (5 * (5 - el[k]));
    chk("seed_ready", k, 32'(sr), 32'(md[k] == 0));
    chk("busy", k, 32'(b), 32'(md[k] != 0));
    chk("load", k, 32'(ld), 32'(md[k] == 1));
    chk("init", k, 32'(ini), 32'(md[k] == 2));
    chk("nlfsr3_ce", k, 32'(ce), 32'(exp_ce(k)));
    chk("d3", k, 32'(d3), md[k] == 1 ? 32'(sh[4:0]) : 32'd0);
    chk("tk", k, 32'(tk), 32'(tk_i));
    chk("ks_valid", k, 32'(v), 32'(mv[k]));
    chk("ks_data", k, dat, mdat[k]);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      md[k] = 0; el[k] = 0; pn[k] = 0; pw[k] = 0; ms[k] = '0; mv[k] = 1'b0; mdat[k] = '0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic ce;
      ce = exp_ce(k);
      if (abort) begin
        md[k] = 0; pn[k] = 0; pw[k] = 0; mv[k] = 1'b0;
      end else if (md[k] == 0) begin
        if (seed_valid) begin ms[k] = seed; md[k] = 1; el[k] = 0; end
      end else if (md[k] == 1) begin
        el[k]++;
        if (el[k] == 6) begin md[k] = 2; el[k] = 0; end
      end else if (md[k] == 2) begin
        el[k]++;
        if (el[k] == rr[k]) begin md[k] = 3; el[k] = 0; end
      end else begin
        if (mv[k] && ks_ready) mv[k] = 1'b0;
        if (ce) begin
          pw[k] = pw[k] * 2 + int'(warbler_bit);
          pn[k]++;
          if (pn[k] == ww[k]) begin mdat[k] = 32'(pw[k]); mv[k] = 1'b1; pn[k] = 0; pw[k] = 0; end
        end
      end
    end
  endtask

  task automatic cyc();
    #1;
    check_dut(0, sr0, ld0, in0, ce0, d30, tk0, v0, 32'(dat0), b0);
    check_dut(1, sr1, ld1, in1, ce1, d31, tk1, v1, 32'(dat1), b1);
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rnd();
    warbler_bit = 1'($urandom);
    tk_i = 5'($urandom);
  endtask

  task automatic to_run0();
    n = 0;
    while (md[0] != 3 && n < 200) begin rnd(); cyc(); n++; end
    chk("reach_run", 0, 32'(in0 | ld0), 32'd0);
  endtask

  initial begin
    rst = 1'b1; seed_valid = 1'b0; seed = '0; abort = 1'b0; warbler_bit = 1'b0; ks_ready = 1'b1; tk_i = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin rnd(); cyc(); end
    seed_valid = 1'b1; seed = 30'h2AAAAAAA;
    cyc();
    seed_valid = 1'b0; seed = 30'($urandom);
    to_run0();
    for (int i = 0; i < 8; i++) begin warbler_bit = pat[i][0]; cyc(); end
    chk("word_b2", 0, 32'(dat0), 32'hB2);
    chk("word_b2_valid", 0, 32'(v0), 32'd1);
    for (int i = 0; i < 8; i++) begin rnd(); cyc(); end
    ks_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin rnd(); cyc(); end
    ks_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin rnd(); cyc(); end
    for (int i = 0; i < 300; i++) begin rnd(); ks_ready = ($urandom_range(0, 3) != 0); cyc(); end
    ks_ready = 1'b1;
    abort = 1'b1; cyc(); abort = 1'b0;
    seed_valid = 1'b1; seed = 30'($urandom); cyc(); seed_valid = 1'b0;
    n = 0;
    while (!(md[0] == 2 && el[0] == 10) && n < 100) begin rnd(); cyc(); n++; end
    abort = 1'b1; seed_valid = 1'b1; seed = 30'($urandom);
    cyc();
    abort = 1'b0;
    chk("abort_idle", 0, 32'({sr0, b0, v0}), 32'b100);
    cyc();
    seed_valid = 1'b0;
    to_run0();
    ks_ready = 1'b0;
    n = 0;
    while (!mv[0] && n < 50) begin rnd(); cyc(); n++; end
    #2 rst = 1'b1;
    #1 model_reset();
    check_dut(0, sr0, ld0, in0, ce0, d30, tk0, v0, 32'(dat0), b0);
    check_dut(1, sr1, ld1, in1, ce1, d31, tk1, v1, 32'(dat1), b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; ks_ready = 1'b1;
    cyc();
    seed_valid = 1'b1; seed = 30'($urandom); cyc(); seed_valid = 1'b0;
    to_run0();
    for (int i = 0; i < 200; i++) begin rnd(); ks_ready = ($urandom_range(0, 2) != 0); cyc(); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
